crash_detector: RTL and testbench

- Produces the crash signals that the enemy renderers, bullet and player blocks consume: crash_enemy_bullet and crash_me_enemy, one bit per enemy layer.
- Sits beside the layer mixer in the clk_vga domain and compares per-pixel alpha from every enemy layer, the bullet layer and the player layer.
- Crash outputs are zero-latency, so each one lands in the same cycle as the enemy's current index.
- Also owns frame-level player damage: lives, invincibility window and game-over.

---
 rtl/crash_detector_pkg.sv | 23 ++
 rtl/crash_detector_frame_edge_det.sv | 30 +++
 rtl/crash_detector.sv | 210 +++++++++++++++++++++
 tb/tb_crash_detector.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crash_detector_pkg.sv
// -----------------------------------------------------------------------------
// crash_detector_pkg
// Shared constants and state encoding for the crash detector and the enemy,
// bullet and player blocks that consume its crash signals.
//   CRASH_*            : default layer count, lives, invincibility and widths
//   crash_state_e      : player damage state (PLAY / HIT / OVER)
// -----------------------------------------------------------------------------
package crash_detector_pkg;

   localparam int CRASH_ENEMY_LAYERS  = 3;
   localparam int CRASH_LIVES         = 3;
   localparam int CRASH_LIVES_BIT_LEN = 2;
   localparam int CRASH_INV_FRAMES    = 120;
   localparam int CRASH_INV_BIT_LEN   = 7;
   localparam int CRASH_HITS_BIT_LEN  = 12;

   typedef enum logic [1:0] {
      CRASH_STATE_PLAY = 2'b00,
      CRASH_STATE_HIT  = 2'b01,
      CRASH_STATE_OVER = 2'b10
   } crash_state_e;

endpackage

// File: rtl/crash_detector_frame_edge_det.sv
// -----------------------------------------------------------------------------
// frame_edge_det
// Registers v_sync and emits a one-cycle frame-boundary pulse on its rising
// edge. The delay register runs every cycle; callers decide whether to act.
//   clk_vga : pixel clock
//   rst     : asynchronous, active-high reset
//   v_sync  : vertical sync in the clk_vga domain
//   fb      : frame boundary pulse (combinational, v_sync & ~v_sync delayed)
// -----------------------------------------------------------------------------
module frame_edge_det (
   input  logic clk_vga,
   input  logic rst,
   input  logic v_sync,
   output logic fb
);

   logic v_sync_d_r;

   // One-cycle delayed copy of v_sync for rising-edge detection.
   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         v_sync_d_r <= 1'b0;
      end else begin
         v_sync_d_r <= v_sync;
      end
   end

   assign fb = v_sync & ~v_sync_d_r;

endmodule

// File: rtl/crash_detector.sv
// -----------------------------------------------------------------------------
// crash_detector
// Per-pixel collision detection between enemy layers, the bullet layer and
// the player layer, plus frame-level player damage bookkeeping.
//   clk_vga              : pixel clock
//   rst                  : asynchronous, active-high reset
//   en_i                 : game running; low freezes all state
//   v_sync_i             : vertical sync (frame boundary on rising edge)
//   enemy_alpha_i        : per-layer enemy alpha of the current pixel
//   bullet_alpha_i       : bullet alpha of the current pixel
//   me_alpha_i           : player alpha of the current pixel
//   crash_enemy_bullet_o : enemy/bullet overlap, same cycle as inputs
//   crash_me_enemy_o     : enemy/player overlap, same cycle as inputs
//   me_hit_o             : one-cycle pulse after a frame boundary costing a life
//   invincible_o         : player currently invincible
//   lives_o              : remaining lives
//   game_over_o          : sticky game over
//   frame_hits_o         : enemy/bullet overlap pixels of the last full frame
// -----------------------------------------------------------------------------
module crash_detector
   import crash_detector_pkg::*;
#(
   parameter int ENEMY_LAYERS  = CRASH_ENEMY_LAYERS,
   parameter int LIVES         = CRASH_LIVES,
   parameter int LIVES_BIT_LEN = CRASH_LIVES_BIT_LEN,
   parameter int INV_FRAMES    = CRASH_INV_FRAMES,
   parameter int INV_BIT_LEN   = CRASH_INV_BIT_LEN,
   parameter int HITS_BIT_LEN  = CRASH_HITS_BIT_LEN
) (
   input  logic                     clk_vga,
   input  logic                     rst,
   input  logic                     en_i,
   input  logic                     v_sync_i,
   input  logic [ENEMY_LAYERS-1:0]  enemy_alpha_i,
   input  logic                     bullet_alpha_i,
   input  logic                     me_alpha_i,
   output logic [ENEMY_LAYERS-1:0]  crash_enemy_bullet_o,
   output logic [ENEMY_LAYERS-1:0]  crash_me_enemy_o,
   output logic                     me_hit_o,
   output logic                     invincible_o,
   output logic [LIVES_BIT_LEN-1:0] lives_o,
   output logic                     game_over_o,
   output logic [HITS_BIT_LEN-1:0]  frame_hits_o
);

   localparam logic [LIVES_BIT_LEN-1:0] LIVES_INIT = LIVES_BIT_LEN'(LIVES);
   localparam logic [LIVES_BIT_LEN-1:0] LIVES_ONE  = {{(LIVES_BIT_LEN-1){1'b0}}, 1'b1};
   localparam logic [LIVES_BIT_LEN-1:0] LIVES_ZERO = {LIVES_BIT_LEN{1'b0}};
   localparam logic [INV_BIT_LEN-1:0]   INV_INIT   = INV_BIT_LEN'(INV_FRAMES);
   localparam logic [INV_BIT_LEN-1:0]   INV_ONE    = {{(INV_BIT_LEN-1){1'b0}}, 1'b1};
   localparam logic [INV_BIT_LEN-1:0]   INV_ZERO   = {INV_BIT_LEN{1'b0}};
   localparam logic [HITS_BIT_LEN-1:0]  HITS_ONE   = {{(HITS_BIT_LEN-1){1'b0}}, 1'b1};
   localparam logic [HITS_BIT_LEN-1:0]  HITS_ZERO  = {HITS_BIT_LEN{1'b0}};
   localparam logic [HITS_BIT_LEN-1:0]  HITS_MAX   = {HITS_BIT_LEN{1'b1}};

   crash_state_e            state_r,      state_s;
   logic [LIVES_BIT_LEN-1:0] lives_r,      lives_s;
   logic [INV_BIT_LEN-1:0]   inv_cnt_r,    inv_cnt_s;
   logic                     me_hit_r,     me_hit_s;
   logic                     me_flag_r,    me_flag_s;
   logic [HITS_BIT_LEN-1:0]  hit_cnt_r,    hit_cnt_s;
   logic [HITS_BIT_LEN-1:0]  frame_hits_r, frame_hits_s;

   logic                     fb_s;
   logic                     game_over_s;
   logic                     invincible_s;
   logic [ENEMY_LAYERS-1:0]  crash_eb_s;
   logic [ENEMY_LAYERS-1:0]  crash_me_s;
   logic                     any_eb_s;
   logic                     any_me_s;

   frame_edge_det u_frame_edge_det (
      .clk_vga (clk_vga),
      .rst     (rst),
      .v_sync  (v_sync_i),
      .fb      (fb_s)
   );

   assign game_over_s  = (state_r == CRASH_STATE_OVER);
   assign invincible_s = (state_r == CRASH_STATE_HIT);

   // Zero-latency overlap masks; player overlap is ignored while invincible.
   always_comb begin
      crash_eb_s = {ENEMY_LAYERS{1'b0}};
      crash_me_s = {ENEMY_LAYERS{1'b0}};
      if (en_i && !game_over_s) begin
         crash_eb_s = enemy_alpha_i & {ENEMY_LAYERS{bullet_alpha_i}};
         if (!invincible_s) begin
            crash_me_s = enemy_alpha_i & {ENEMY_LAYERS{me_alpha_i}};
         end else begin
            crash_me_s = {ENEMY_LAYERS{1'b0}};
         end
      end else begin
         crash_eb_s = {ENEMY_LAYERS{1'b0}};
         crash_me_s = {ENEMY_LAYERS{1'b0}};
      end
   end

   assign any_eb_s = |crash_eb_s;
   assign any_me_s = |crash_me_s;

   // Per-frame accumulation: player-touch flag and saturating hit-pixel count.
   // A crash in the boundary cycle itself belongs to the new frame.
   always_comb begin
      me_flag_s    = me_flag_r;
      hit_cnt_s    = hit_cnt_r;
      frame_hits_s = frame_hits_r;
      if (en_i) begin
         if (fb_s) begin
            me_flag_s    = 1'b0;
            frame_hits_s = hit_cnt_r;
            hit_cnt_s    = any_eb_s ? HITS_ONE : HITS_ZERO;
         end else begin
            if (any_me_s) begin
               me_flag_s = 1'b1;
            end else begin
               me_flag_s = me_flag_r;
            end
            if (any_eb_s && (hit_cnt_r != HITS_MAX)) begin
               hit_cnt_s = hit_cnt_r + HITS_ONE;
            end else begin
               hit_cnt_s = hit_cnt_r;
            end
         end
      end else begin
         me_flag_s    = me_flag_r;
         hit_cnt_s    = hit_cnt_r;
         frame_hits_s = frame_hits_r;
      end
   end

   // Damage state machine; it only advances on an enabled frame boundary.
   always_comb begin
      state_s   = state_r;
      lives_s   = lives_r;
      inv_cnt_s = inv_cnt_r;
      me_hit_s  = 1'b0;
      if (en_i && fb_s) begin
         case (state_r)
            CRASH_STATE_PLAY: begin
               if (me_flag_r) begin
                  me_hit_s = 1'b1;
                  if (lives_r > LIVES_ONE) begin
                     state_s   = CRASH_STATE_HIT;
                     lives_s   = lives_r - LIVES_ONE;
                     inv_cnt_s = INV_INIT;
                  end else begin
                     // Last life (or none left): never wrap below zero.
                     state_s   = CRASH_STATE_OVER;
                     lives_s   = LIVES_ZERO;
                     inv_cnt_s = INV_ZERO;
                  end
               end else begin
                  state_s = CRASH_STATE_PLAY;
               end
            end
            CRASH_STATE_HIT: begin
               if (inv_cnt_r <= INV_ONE) begin
                  state_s   = CRASH_STATE_PLAY;
                  inv_cnt_s = INV_ZERO;
               end else begin
                  inv_cnt_s = inv_cnt_r - INV_ONE;
               end
            end
            CRASH_STATE_OVER: begin
               state_s = CRASH_STATE_OVER;
               lives_s = LIVES_ZERO;
            end
            default: begin
               // Unreachable encoding: fail safe into game over.
               state_s   = CRASH_STATE_OVER;
               lives_s   = LIVES_ZERO;
               inv_cnt_s = INV_ZERO;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         state_r      <= CRASH_STATE_PLAY;
         lives_r      <= LIVES_INIT;
         inv_cnt_r    <= INV_ZERO;
         me_hit_r     <= 1'b0;
         me_flag_r    <= 1'b0;
         hit_cnt_r    <= HITS_ZERO;
         frame_hits_r <= HITS_ZERO;
      end else begin
         state_r      <= state_s;
         lives_r      <= lives_s;
         inv_cnt_r    <= inv_cnt_s;
         me_hit_r     <= me_hit_s;
         me_flag_r    <= me_flag_s;
         hit_cnt_r    <= hit_cnt_s;
         frame_hits_r <= frame_hits_s;
      end
   end

   assign crash_enemy_bullet_o = crash_eb_s;
   assign crash_me_enemy_o     = crash_me_s;
   assign me_hit_o             = me_hit_r;
   assign invincible_o         = invincible_s;
   assign lives_o              = lives_r;
   assign game_over_o          = game_over_s;
   assign frame_hits_o         = frame_hits_r;

endmodule

// File: tb/tb_crash_detector.sv
// -----------------------------------------------------------------------------
// tb_crash_detector
// Directed scenarios followed by randomized frames. A frame-level model
// (lives, frames of invincibility left, pixel tally) predicts every output on
// each falling clock edge; directed steps also pin literal values.
// -----------------------------------------------------------------------------
module tb_crash_detector;

   localparam int INV      = 2;
   localparam int HITS_SAT = 4095;

   logic       clk_vga = 1'b0;
   logic       rst     = 1'b1;
   logic       en      = 1'b0;
   logic       vs      = 1'b0;
   logic [2:0] ea      = 3'b000;
   logic       ba      = 1'b0;
   logic       ma      = 1'b0;
   logic [2:0] crash_eb, crash_me;
   logic       me_hit, invincible, game_over;
   logic [1:0] lives;
   logic [11:0] frame_hits;

   int total = 0;
   int bad   = 0;

   // model state
   int         m_lives, m_inv, m_pix, m_fh;
   bit         m_touch, m_prev_vs, m_hit, m_fb;
   logic [2:0] e_eb, e_me;

   crash_detector #(.INV_FRAMES(INV)) dut (
      .clk_vga              (clk_vga),
      .rst                  (rst),
      .en_i                 (en),
      .v_sync_i             (vs),
      .enemy_alpha_i        (ea),
      .bullet_alpha_i       (ba),
      .me_alpha_i           (ma),
      .crash_enemy_bullet_o (crash_eb),
      .crash_me_enemy_o     (crash_me),
      .me_hit_o             (me_hit),
      .invincible_o         (invincible),
      .lives_o              (lives),
      .game_over_o          (game_over),
      .frame_hits_o         (frame_hits)
   );

   always #5 clk_vga = ~clk_vga;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lives = 3; m_inv = 0; m_pix = 0; m_fh = 0;
      m_touch = 1'b0; m_prev_vs = 1'b0; m_hit = 1'b0;
   endtask

   // Frame-level reference: check all outputs, then advance one clock.
   always @(negedge clk_vga) begin
      if (rst) model_reset();
      e_eb = (en && m_lives > 0) ? (ea & {3{ba}}) : 3'b000;
      e_me = (en && m_lives > 0 && m_inv == 0) ? (ea & {3{ma}}) : 3'b000;
      chk("crash_enemy_bullet", crash_eb, e_eb);
      chk("crash_me_enemy", crash_me, e_me);
      chk("me_hit", me_hit, m_hit);
      chk("invincible", invincible, (m_inv > 0));
      chk("lives", lives, m_lives);
      chk("game_over", game_over, (m_lives == 0));
      chk("frame_hits", frame_hits, m_fh);
      if (!rst) begin
         m_fb      = vs && !m_prev_vs;
         m_prev_vs = vs;
         m_hit     = 1'b0;
         if (en) begin
            if (m_fb) begin
               m_fh  = m_pix;
               m_pix = (e_eb != 3'b000) ? 1 : 0;
               if (m_inv > 0) begin
                  m_inv--;
               end else if (m_touch && m_lives > 0) begin
                  m_lives--;
                  m_hit = 1'b1;
                  if (m_lives > 0) m_inv = INV;
               end
               m_touch = 1'b0;
            end else begin
               if (e_eb != 3'b000 && m_pix < HITS_SAT) m_pix++;
               if (e_me != 3'b000) m_touch = 1'b1;
            end
         end
      end
   end

   task automatic set_in(input bit e, input bit v, input logic [2:0] a, input bit b, input bit m);
      en = e; vs = v; ea = a; ba = b; ma = m;
   endtask

   task automatic tick();
      @(posedge clk_vga);
      #1;
   endtask

   task automatic cyc(input bit e, input bit v, input logic [2:0] a, input bit b, input bit m);
      set_in(e, v, a, b, m);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
   endtask

   // Enabled frame boundary; returns one cycle later with v_sync low again.
   task automatic fb_cyc();
      cyc(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
      set_in(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      idle(3);

      // 1: five enemy/bullet overlap cycles on layer 1
      set_in(1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
      #1;
      chk("t1_crash_eb_lit", crash_eb, 3'b010);
      chk("t1_crash_me_lit", crash_me, 3'b000);
      tick();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 3'b010, 1'b1, 1'b0);
      idle(2);
      fb_cyc();
      chk("t1_frame_hits_lit", frame_hits, 5);
      chk("t1_lives_lit", lives, 3);

      // 2: one player overlap costs a life and starts invincibility
      cyc(1'b1, 1'b0, 3'b001, 1'b0, 1'b1);
      idle(1);
      fb_cyc();
      chk("t2_me_hit_lit", me_hit, 1);
      chk("t2_lives_lit", lives, 2);
      chk("t2_invincible_lit", invincible, 1);
      idle(1);
      chk("t2_me_hit_drop_lit", me_hit, 0);
      set_in(1'b1, 1'b0, 3'b001, 1'b0, 1'b1);
      #1;
      chk("t2_masked_lit", crash_me, 3'b000);
      tick();
      idle(1);

      // 3: invincibility lasts two boundaries, then overlap hurts again
      fb_cyc();
      chk("t3_still_inv_lit", invincible, 1);
      idle(3);
      fb_cyc();
      chk("t3_inv_drop_lit", invincible, 0);
      set_in(1'b1, 1'b0, 3'b100, 1'b0, 1'b1);
      #1;
      chk("t3_crash_me_lit", crash_me, 3'b100);
      tick();
      idle(1);
      fb_cyc();
      chk("t3_lives_lit", lives, 1);

      // 4: third hit ends the game; everything masked and sticky
      idle(1); fb_cyc(); idle(1); fb_cyc();
      cyc(1'b1, 1'b0, 3'b011, 1'b0, 1'b1);
      idle(1);
      fb_cyc();
      chk("t4_lives_lit", lives, 0);
      chk("t4_game_over_lit", game_over, 1);
      chk("t4_me_hit_lit", me_hit, 1);
      set_in(1'b1, 1'b0, 3'b111, 1'b1, 1'b1);
      #1;
      chk("t4_eb_masked_lit", crash_eb, 3'b000);
      chk("t4_me_masked_lit", crash_me, 3'b000);
      tick();
      idle(1); fb_cyc(); idle(1);
      chk("t4_sticky_lit", game_over, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t4_rst_clears_lit", game_over, 0);
      chk("t4_rst_lives_lit", lives, 3);

      // 5: counter saturation and boundary-cycle crash carried forward
      idle(1); fb_cyc();
      for (int i = 0; i < 5000; i++) cyc(1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 3'b100, 1'b1, 1'b0);
      chk("t5_saturate_lit", frame_hits, 4095);
      idle(3);
      fb_cyc();
      chk("t5_carry_lit", frame_hits, 1);

      // 6: disabled boundary is ignored, then async reset mid-cycle
      cyc(1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 3'b010, 1'b1, 1'b1);
      idle(1);
      cyc(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      chk("t6_lives_hold_lit", lives, 3);
      chk("t6_no_hit_lit", me_hit, 0);
      idle(2);
      fb_cyc();
      chk("t6_late_hit_lit", me_hit, 1);
      chk("t6_late_lives_lit", lives, 2);
      chk("t6_frame_hits_lit", frame_hits, 2);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_lives_lit", lives, 3);
      chk("t6_async_inv_lit", invincible, 0);
      chk("t6_async_hit_lit", me_hit, 0);
      chk("t6_async_fh_lit", frame_hits, 0);
      chk("t6_async_go_lit", game_over, 0);
      tick();
      rst = 1'b0;

      // randomized frames
      for (int f = 0; f < 250; f++) begin
         int len;
         len = $urandom_range(6, 40);
         for (int c = 0; c < len; c++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0), 3'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 47) == 0));
         end
         if ($urandom_range(0, 11) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         cyc(($urandom_range(0, 7) != 0), 1'b1, 3'($urandom),
             ($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0));
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
